line_buf_ctrl_1bit: RTL

Controller that sequences two external 1-bit line-buffer FIFOs into a 3-row vertical window for the binary erosion/dilation path. It accepts the thresholded 1-bit pixel stream and cascades rows through the FIFOs: current → FIFO0 → FIFO1. It emits three vertically aligned taps per pixel to the 3×3 morphology kernel. It owns fill, steady-state and drain sequencing, so the FIFO instances stay plain IP.

---
 rtl/line_buf_ctrl_1bit_pkg.sv | 14 +
 rtl/line_buf_ctrl_1bit_if.sv | 41 ++++
 rtl/line_buf_ctrl_1bit.sv | 108 ++++++++++
 3 files changed

// File: rtl/line_buf_ctrl_1bit_pkg.sv
// Shared types for the 1-bit line-buffer controller: FSM states and FIFO read latency.
package lb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LINE0,
    LINE1,
    RUN,
    FLUSH
  } lb_state_t;

  localparam int LB_RD_LAT = 1;

endpackage

// File: rtl/line_buf_ctrl_1bit_if.sv
// Pixel stream, FIFO ports and window outputs of the line-buffer controller.
// master = controller view, slave = surrounding fabric (FIFOs, source, kernel).
interface line_buf_ctrl_1bit_if #(
  parameter int CNT_W = 8
) ();
  logic             pix_vld;
  logic             pix_data;
  logic             pix_sof;
  logic             fifo0_wr_en;
  logic             fifo0_wr_data;
  logic             fifo0_rd_en;
  logic             fifo0_rd_data;
  logic             fifo0_rd_empty;
  logic             fifo1_wr_en;
  logic             fifo1_wr_data;
  logic             fifo1_rd_en;
  logic             fifo1_rd_data;
  logic             fifo1_rd_empty;
  logic             win_vld;
  logic             tap_new;
  logic             tap_mid;
  logic             tap_old;
  logic             busy;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    input  pix_vld, pix_data, pix_sof,
    input  fifo0_rd_data, fifo0_rd_empty, fifo1_rd_data, fifo1_rd_empty,
    output fifo0_wr_en, fifo0_wr_data, fifo0_rd_en,
    output fifo1_wr_en, fifo1_wr_data, fifo1_rd_en,
    output win_vld, tap_new, tap_mid, tap_old, busy, drop_cnt
  );

  modport slave (
    output pix_vld, pix_data, pix_sof,
    output fifo0_rd_data, fifo0_rd_empty, fifo1_rd_data, fifo1_rd_empty,
    input  fifo0_wr_en, fifo0_wr_data, fifo0_rd_en,
    input  fifo1_wr_en, fifo1_wr_data, fifo1_rd_en,
    input  win_vld, tap_new, tap_mid, tap_old, busy, drop_cnt
  );
endinterface

// File: rtl/line_buf_ctrl_1bit.sv
// Cascades a 1-bit pixel stream through two external line FIFOs (cur -> FIFO0 -> FIFO1)
// and emits a registered 3-row vertical tap set per pixel for the morphology kernel.
module line_buf_ctrl_1bit
  import lb_pkg::*;
#(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720,
  parameter int CNT_W      = 8
) (
  input logic                  clk,
  input logic                  rst,
  line_buf_ctrl_1bit_if.master bus
);

  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int STAGES = LB_RD_LAT + 1;

  lb_state_t        state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] drop_q;
  logic [STAGES:1]  vld_pipe;
  logic             pix_d, rd0_d;
  logic             tap_new_q, tap_mid_q, tap_old_q;
  logic             vld, in_frame, flush, premature, acc, run_acc, rd0_cas;
  logic             last_col, last_pix;

  always_comb begin
    vld       = bus.pix_vld & ~rst;
    in_frame  = (state == LINE0) | (state == LINE1) | (state == RUN);
    flush     = (state == FLUSH) & ~rst;
    premature = vld & bus.pix_sof & in_frame;
    acc       = vld & (((state == IDLE) & bus.pix_sof) | (in_frame & ~bus.pix_sof));
    rd0_cas   = acc & ((state == LINE1) | (state == RUN));
    run_acc   = acc & (state == RUN);
    last_col  = (col == COL_W'(IMG_WIDTH - 1));
    last_pix  = last_col & (row == ROW_W'(IMG_HEIGHT - 1));
  end

  assign bus.fifo0_wr_en   = acc;
  assign bus.fifo0_wr_data = bus.pix_data;
  assign bus.fifo0_rd_en   = rd0_cas | (flush & ~bus.fifo0_rd_empty);
  assign bus.fifo1_rd_en   = run_acc | (flush & ~bus.fifo1_rd_empty);
  // The row leaving FIFO0 becomes the row entering FIFO1 once its data lands.
  assign bus.fifo1_wr_en   = rd0_d & (state != FLUSH) & ~rst;
  assign bus.fifo1_wr_data = bus.fifo0_rd_data;
  assign bus.win_vld       = vld_pipe[STAGES];
  assign bus.tap_new       = tap_new_q;
  assign bus.tap_mid       = tap_mid_q;
  assign bus.tap_old       = tap_old_q;
  assign bus.busy          = (state != IDLE);
  assign bus.drop_cnt      = drop_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (acc) state_nxt = LINE0;
      LINE0: if (premature) state_nxt = FLUSH;
             else if (acc && last_col) state_nxt = LINE1;
      LINE1: if (premature) state_nxt = FLUSH;
             else if (acc && last_col) state_nxt = RUN;
      RUN:   if (premature || (acc && last_pix)) state_nxt = FLUSH;
      FLUSH: if (bus.fifo0_rd_empty && bus.fifo1_rd_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      drop_q    <= '0;
      vld_pipe  <= '0;
      pix_d     <= 1'b0;
      rd0_d     <= 1'b0;
      tap_new_q <= 1'b0;
      tap_mid_q <= 1'b0;
      tap_old_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd0_d    <= rd0_cas;
      vld_pipe <= {vld_pipe[STAGES-1:1], run_acc};
      if (run_acc) pix_d <= bus.pix_data;
      // FIFO read data is valid one cycle after the read, aligned with pix_d.
      if (vld_pipe[STAGES-1]) begin
        tap_new_q <= pix_d;
        tap_mid_q <= bus.fifo0_rd_data;
        tap_old_q <= bus.fifo1_rd_data;
      end
      if (acc) begin
        if (state == IDLE) begin
          col <= COL_W'(1);
          row <= '0;
        end else if (last_col) begin
          col <= '0;
          row <= last_pix ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if ((premature || (vld && state == FLUSH)) && drop_q != {CNT_W{1'b1}})
        drop_q <= drop_q + CNT_W'(1);
    end
  end

endmodule
